smvm_result_collector: RTL and testbench

SMVM_RESULT_COLLECTOR -- requirements
Module: smvm_result_collector

---
 rtl/smvm_result_collector_if.sv | 27 ++
 rtl/smvm_result_collector.sv | 116 +++++++++++
 tb/tb_smvm_result_collector.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/smvm_result_collector_if.sv
// Handshake bundle between the SMVM half-word stream, the result collector
// and the downstream consumer of saturated results.
interface smvm_result_collector_if #(
    parameter int SAT_W = 16
) ();
    logic             start;
    logic [7:0]       row_total;
    logic             in_valid;
    logic [13:0]      data_in;
    logic             out_ready;
    logic             out_valid;
    logic [SAT_W-1:0] out_data;
    logic             out_last;
    logic             out_sat;
    logic             overflow;
    logic             done;

    modport master (
        output start, row_total, in_valid, data_in, out_ready,
        input  out_valid, out_data, out_last, out_sat, overflow, done
    );

    modport slave (
        input  start, row_total, in_valid, data_in, out_ready,
        output out_valid, out_data, out_last, out_sat, overflow, done
    );
endinterface

// File: rtl/smvm_result_collector.sv
// Reassembles 28-bit SMVM results from half-words, saturates them to SAT_W
// bits and queues them in a small FIFO with per-frame last/done signalling.
module smvm_result_collector #(
    parameter int FIFO_DEPTH = 8,
    parameter int SAT_W      = 16
) (
    input logic                    clk,
    input logic                    rst,
    smvm_result_collector_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [27:0] SMAX = 28'((29'sd1 <<< (SAT_W - 1)) - 29'sd1);
    localparam logic signed [27:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, HI, LO, DRAIN} state_e;

    state_e           state_q;
    logic [7:0]       total_q, rows_q;
    logic [13:0]      hi_q;
    logic             done_q, ovf_q;
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic [SAT_W+1:0] mem [FIFO_DEPTH];

    logic signed [27:0] word;
    logic [SAT_W-1:0]   sat_val;
    logic               clip;
    logic [7:0]         rows_nxt;
    logic               is_last, push_req, push_ok, pop, full, empty;
    logic [SAT_W+1:0]   head;

    assign word     = {hi_q, bus.data_in};
    assign rows_nxt = rows_q + 8'd1;
    assign is_last  = (rows_nxt == total_q);
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop      = !empty && bus.out_ready;
    assign push_req = (state_q == LO) && bus.in_valid;
    // pop is already false when empty, so a push into an empty FIFO just becomes head
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        clip    = 1'b0;
        sat_val = word[SAT_W-1:0];
        if (word > SMAX) begin
            clip    = 1'b1;
            sat_val = SMAX[SAT_W-1:0];
        end else if (word < SMIN) begin
            clip    = 1'b1;
            sat_val = SMIN[SAT_W-1:0];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            total_q <= '0;
            rows_q  <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_d;
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            if (push_req && !push_ok) ovf_q <= 1'b1;
            case (state_q)
                IDLE: if (bus.start) begin
                    total_q <= bus.row_total;
                    rows_q  <= '0;
                    state_q <= (bus.row_total == 8'd0) ? DRAIN : HI;
                end
                HI: if (bus.in_valid) begin
                    hi_q    <= bus.data_in;
                    state_q <= LO;
                end
                // row count advances whether or not the push was accepted
                LO: if (bus.in_valid) begin
                    rows_q  <= rows_nxt;
                    state_q <= is_last ? DRAIN : HI;
                end
                DRAIN: if (empty) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= {clip, is_last, sat_val};
    end

    // head fields are gated so every output reads 0 while the FIFO is empty or in reset
    assign head          = mem[rd_q];
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0   : head[SAT_W-1:0];
    assign bus.out_last  = empty ? 1'b0 : head[SAT_W];
    assign bus.out_sat   = empty ? 1'b0 : head[SAT_W+1];
    assign bus.overflow  = ovf_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_smvm_result_collector.sv
// Directed bench for smvm_result_collector: framing, saturation, overflow,
// full-FIFO push with pop, empty frames and mid-frame reset.
module tb_smvm_result_collector;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    smvm_result_collector_if #(.SAT_W(16)) bus ();

    smvm_result_collector #(.FIFO_DEPTH(8), .SAT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] total);
        bus.start = 1'b1;
        bus.row_total = total;
        tick();
        bus.start = 1'b0;
    endtask

    // leaves in_valid high; caller drops it when the stream pauses
    task automatic send(input logic [13:0] hi, input logic [13:0] lo);
        bus.in_valid = 1'b1;
        bus.data_in = hi;
        tick();
        bus.data_in = lo;
        tick();
    endtask

    task automatic chk_head(input string tag, input logic [15:0] d, input logic l, input logic s);
        chk({tag, " valid"}, bus.out_valid, 1);
        chk({tag, " data"},  bus.out_data, d);
        chk({tag, " last"},  bus.out_last, l);
        chk({tag, " sat"},   bus.out_sat, s);
    endtask

    task automatic wait_done(input string tag, input int max);
        int seen = 0;
        for (int i = 0; i < max && seen == 0; i++) begin
            tick();
            if (bus.done) seen = 1;
        end
        chk({tag, " done seen"}, seen, 1);
        if (seen != 0) begin
            tick();
            chk({tag, " done one cycle"}, bus.done, 0);
        end
    endtask

    logic [13:0] hi_t [6];
    logic [13:0] lo_t [6];
    logic [15:0] d_t  [6];
    logic        s_t  [6];

    initial begin
        hi_t = '{14'h1FFF, 14'h2000, 14'h0001, 14'h3FFE, 14'h0002, 14'h3FFD};
        lo_t = '{14'h3FFF, 14'h0000, 14'h3FFF, 14'h0000, 14'h0000, 14'h3FFF};
        d_t  = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        s_t  = '{1'b1,     1'b1,     1'b0,     1'b0,     1'b1,     1'b1};

        rst = 1'b1;
        bus.start = 1'b0; bus.row_total = '0; bus.in_valid = 1'b0;
        bus.data_in = '0; bus.out_ready = 1'b0;
        tick(); tick();
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_data",  bus.out_data, 0);
        chk("rst out_last",  bus.out_last, 0);
        chk("rst out_sat",   bus.out_sat, 0);
        chk("rst overflow",  bus.overflow, 0);
        chk("rst done",      bus.done, 0);
        rst = 1'b0;
        tick();

        // two-row frame, streaming straight out
        bus.out_ready = 1'b1;
        do_start(8'd2);
        send(14'h0000, 14'h1234);
        chk_head("basic r0", 16'h1234, 0, 0);
        send(14'h3FFF, 14'h3FFF);
        chk_head("basic r1", 16'hFFFF, 1, 0);
        bus.in_valid = 1'b0;
        wait_done("basic", 4);

        // saturation and exact-boundary values, held in the FIFO then popped
        bus.out_ready = 1'b0;
        do_start(8'd6);
        for (int i = 0; i < 6; i++) send(hi_t[i], lo_t[i]);
        bus.in_valid = 1'b0;
        tick();
        chk("sat done held", bus.done, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_head($sformatf("sat r%0d", i), d_t[i], (i == 5), s_t[i]);
            tick();
        end
        chk("sat empty", bus.out_valid, 0);
        wait_done("sat", 3);
        chk("sat no overflow", bus.overflow, 0);

        // overflow: 10 rows into an 8-deep FIFO with no consumer
        bus.out_ready = 1'b0;
        do_start(8'd10);
        for (int i = 1; i <= 10; i++) begin
            send(14'h0000, 14'(i));
            if (i == 8) chk("ovf after 8", bus.overflow, 0);
            if (i == 9) chk("ovf after 9", bus.overflow, 1);
        end
        bus.in_valid = 1'b0;
        tick(); tick();
        chk("ovf done held", bus.done, 0);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk_head($sformatf("ovf r%0d", i), 16'(i), 0, 0);
            tick();
        end
        chk("ovf empty", bus.out_valid, 0);
        wait_done("ovf", 3);
        chk("ovf sticky", bus.overflow, 1);
        rst = 1'b1;
        #1;
        chk("ovf async clear", bus.overflow, 0);
        tick();
        rst = 1'b0;
        tick();

        // full FIFO with pop in the same cycle as the LO push
        bus.out_ready = 1'b0;
        do_start(8'd9);
        for (int i = 0; i < 8; i++) send(14'h0000, 14'(16 + i));
        bus.data_in = 14'h0000;
        tick();
        bus.out_ready = 1'b1;
        bus.data_in = 14'h0018;
        tick();
        bus.in_valid = 1'b0;
        chk("full no overflow", bus.overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            chk_head($sformatf("full r%0d", i), 16'(16 + i), (i == 8), 0);
            tick();
        end
        chk("full empty", bus.out_valid, 0);
        wait_done("full", 3);

        // empty frame: done follows start, in_valid ignored
        do_start(8'd0);
        bus.in_valid = 1'b1;
        bus.data_in = 14'h0AAA;
        wait_done("zero", 2);
        tick(); tick();
        chk("zero no output", bus.out_valid, 0);
        bus.in_valid = 1'b0;

        // reset between halves, then a fresh frame
        bus.out_ready = 1'b0;
        do_start(8'd1);
        bus.in_valid = 1'b1;
        bus.data_in = 14'h3FFF;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst out_valid", bus.out_valid, 0);
        tick();
        bus.data_in = 14'h0055;
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("midrst ignored", bus.out_valid, 0);
        bus.in_valid = 1'b0;
        do_start(8'd1);
        send(14'h0000, 14'h0055);
        bus.in_valid = 1'b0;
        chk_head("midrst new", 16'h0055, 1, 0);
        bus.out_ready = 1'b1;
        wait_done("midrst", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
